// File: rtl/col_parity_accumulator.sv
// Column-parity accumulator: folds a column-major stream of 25 lanes into five
// column parities C[x] and hands each one downstream over valid/ready.
module col_parity_accumulator #(
  parameter int LANE_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANE_W-1:0] in_lane,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_parity,
  output logic [2:0]        out_col,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_EMIT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        row_q, row_d;
  logic [2:0]        col_q, col_d;
  logic [LANE_W-1:0] acc_q, acc_d;
  logic [LANE_W-1:0] parity_q, parity_d;
  logic [2:0]        out_col_q, out_col_d;

  logic lane_xfer;
  logic out_xfer;

  // Handshake qualifiers are pure decodes of the state, so input and output
  // phases can never overlap.
  assign in_ready   = (state_q == S_ACCUM);
  assign out_valid  = (state_q == S_EMIT);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign out_parity = parity_q;
  assign out_col    = out_col_q;

  assign lane_xfer = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    acc_d     = acc_q;
    parity_d  = parity_q;
    out_col_d = out_col_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          row_d   = '0;
          col_d   = '0;
          acc_d   = '0;
        end
      end

      S_ACCUM: begin
        if (lane_xfer) begin
          // Row wrap 4 -> 0 is the column-complete carry.
          if (row_q == 3'd4) begin
            parity_d  = acc_q ^ in_lane;
            out_col_d = col_q;
            row_d     = '0;
            state_d   = S_EMIT;
          end else begin
            acc_d = (row_q == 3'd0) ? in_lane : (acc_q ^ in_lane);
            row_d = row_q + 3'd1;
          end
        end
      end

      S_EMIT: begin
        if (out_xfer) begin
          if (col_q == 3'd4) begin
            col_d   = '0;
            state_d = S_DONE;
          end else begin
            col_d   = col_q + 3'd1;
            state_d = S_ACCUM;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      acc_q     <= '0;
      parity_q  <= '0;
      out_col_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      acc_q     <= acc_d;
      parity_q  <= parity_d;
      out_col_q <= out_col_d;
    end
  end

endmodule

// File: tb/tb_col_parity_accumulator.sv
// Self-checking bench for col_parity_accumulator: expected column parities are
// queued as lanes are driven and compared when the block presents them.
module tb_col_parity_accumulator;

  localparam int LANE_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [LANE_W-1:0] in_lane;
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_parity;
  logic [2:0]        out_col;
  logic              busy;
  logic              done;

  typedef struct packed {
    logic [2:0]        col;
    logic [LANE_W-1:0] par;
  } exp_t;

  exp_t              sb_q[$];
  logic [LANE_W-1:0] lanes [25];
  int                checks   = 0;
  int                failures = 0;

  col_parity_accumulator #(.LANE_W(LANE_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_lane   (in_lane),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_parity(out_parity),
    .out_col   (out_col),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Check that every output sits at its reset value.
  task automatic check_idle_zero(input string tag);
    checks++;
    if ({in_ready, out_valid, busy, done} !== 4'b0000 || out_parity !== '0 || out_col !== 3'd0) begin
      failures++;
      $display("FAIL %s: in_ready=%b out_valid=%b busy=%b done=%b parity=%h col=%0d, expected all zero",
               tag, in_ready, out_valid, busy, done, out_parity, out_col);
    end
  endtask

  // Drive one frame from `lanes`. Expected parities are pushed on the 5th lane
  // of each column and compared while out_valid is high.
  task automatic run_frame(input string tag, input bit gaps, input int stall_col,
                           input int stall_len, input int busy_start_lane,
                           input int abort_lane, input bit start_on_done,
                           input int exp_done_cyc);
    int                cyc;
    int                lane;
    int                stall_cnt;
    int                done_seen;
    bit                started_busy;
    logic [LANE_W-1:0] par_acc;
    exp_t              e;

    cyc = 0; lane = 0; stall_cnt = 0; done_seen = 0; started_busy = 1'b0; par_acc = '0;
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s start: busy=%b in_ready=%b, expected 1/1", tag, busy, in_ready);
    end

    while (cyc < 400) begin
      start    = 1'b0;
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_lane  = (in_valid && lane < 25) ? lanes[lane] : {$urandom, $urandom};
      if (busy_start_lane >= 0 && lane == busy_start_lane && !started_busy) begin
        start = 1'b1;
        started_busy = 1'b1;
      end
      if (start_on_done && done) start = 1'b1;
      out_ready = !(out_valid && out_col == 3'(stall_col) && stall_cnt < stall_len);

      @(negedge clk);
      if (in_valid && in_ready) begin
        if (lane < 25) begin
          par_acc = (lane % 5 == 0) ? lanes[lane] : (par_acc ^ lanes[lane]);
          if (lane % 5 == 4) begin
            e.col = 3'(lane / 5);
            e.par = par_acc;
            sb_q.push_back(e);
          end
        end
        lane++;
      end
      checks++;
      if (in_ready && out_valid) begin
        failures++;
        $display("FAIL %s overlap: in_ready=%b out_valid=%b at cycle %0d", tag, in_ready, out_valid, cyc);
      end
      if (out_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL %s unexpected output: col=%0d parity=%h with empty scoreboard", tag, out_col, out_parity);
        end else if (out_col !== sb_q[0].col || out_parity !== sb_q[0].par) begin
          failures++;
          $display("FAIL %s parity: got col=%0d parity=%h, expected col=%0d parity=%h",
                   tag, out_col, out_parity, sb_q[0].col, sb_q[0].par);
        end
        if (out_ready) begin
          if (sb_q.size() != 0) void'(sb_q.pop_front());
        end else begin
          stall_cnt++;
        end
      end
      if (done) begin
        done_seen++;
        checks++;
        if (lane != 25 || sb_q.size() != 0) begin
          failures++;
          $display("FAIL %s done: lanes=%0d pending=%0d, expected 25/0", tag, lane, sb_q.size());
        end
        if (exp_done_cyc > 0) begin
          checks++;
          if (cyc != exp_done_cyc) begin
            failures++;
            $display("FAIL %s done timing: done at cycle %0d, expected %0d", tag, cyc, exp_done_cyc);
          end
        end
      end

      @(posedge clk); #1;
      cyc++;
      if (abort_lane >= 0 && lane >= abort_lane) return;
      if (done_seen != 0) break;
    end

    checks++;
    if (cyc >= 400) begin
      failures++;
      $display("FAIL %s timeout: no done after %0d cycles", tag, cyc);
    end else if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s after done: done=%b busy=%b, expected 0/0", tag, done, busy);
    end
    start = 1'b0;
    if (stall_len > 0) begin
      checks++;
      if (stall_cnt != stall_len) begin
        failures++;
        $display("FAIL %s stall length: stalled %0d cycles, expected %0d", tag, stall_cnt, stall_len);
      end
    end
  endtask

  task automatic fill_pattern();
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        lanes[x*5+y] = {8{4'(x), 4'(y)}};
  endtask

  task automatic fill_random();
    for (int i = 0; i < 25; i++) lanes[i] = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_lane = '0;
    #12;
    check_idle_zero("reset");
    in_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    check_idle_zero("reset held");
    start = 1'b0; in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check_idle_zero("idle ignores in_valid");
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    fill_pattern();
    run_frame("basic", 1'b0, -1, 0, -1, -1, 1'b0, 31);
  endtask

  task automatic test_constant();
    for (int i = 0; i < 25; i++) lanes[i] = '1;
    run_frame("all ones", 1'b0, -1, 0, -1, -1, 1'b0, 31);
    for (int i = 0; i < 25; i++) lanes[i] = (i % 5 < 2) ? 64'h1 : 64'h0;
    run_frame("pair cancel", 1'b0, -1, 0, -1, -1, 1'b0, 31);
  endtask

  task automatic test_gaps();
    fill_pattern();
    run_frame("gaps", 1'b1, -1, 0, -1, -1, 1'b0, 0);
    fill_random();
    run_frame("gaps random", 1'b1, -1, 0, -1, -1, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    fill_random();
    run_frame("backpressure", 1'b0, 2, 7, -1, -1, 1'b0, 38);
  endtask

  task automatic test_start_while_busy();
    fill_random();
    run_frame("start busy", 1'b0, -1, 0, 12, -1, 1'b0, 31);
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_frame("start on done", 1'b0, -1, 0, -1, -1, 1'b1, 31);
    fill_random();
    run_frame("back to back", 1'b0, -1, 0, -1, -1, 1'b0, 31);
  endtask

  task automatic test_reset_mid_frame();
    fill_random();
    run_frame("pre-abort", 1'b0, -1, 0, -1, 8, 1'b0, 0);
    #2;
    reset = 1'b0;
    #1;
    check_idle_zero("reset mid-frame");
    sb_q.delete();
    start = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_zero("reset hold");
    end
    reset = 1'b1;
    in_valid = 1'b0;
    fill_random();
    run_frame("after abort", 1'b0, -1, 0, -1, -1, 1'b0, 31);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_constant();
    test_gaps();
    test_backpressure();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/col_parity_accumulator.md
Name: col_parity_accumulator

Overview:
- Consumes one 5x5 state frame as a stream of 25 lanes, column-major: column x = 0..4, rows y = 0..4 within each column.
- Computes and emits each column parity C[x] = A[x,0] ^ A[x,1] ^ A[x,2] ^ A[x,3] ^ A[x,4].
- Sits directly downstream of the modulo-5 row/column sequencing: the internal row counter wraps at 4, and the wrap acts as the column-complete carry.
- Feeds the theta-mixing stage through a valid/ready output.

Parameters:
- LANE_W, 64, lane and parity width in bits. Row and column counts are fixed at 5.

Ports:
- clk  input  1  system clock; rising edge active.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- start  input  1  single-cycle pulse that begins a frame; honoured only in IDLE.
- in_valid  input  1  in_lane holds a valid lane.
- in_ready  output  1  block accepts a lane this cycle.
- in_lane  input  LANE_W  lane A[x,y].
- out_valid  output  1  out_parity/out_col are valid.
- out_ready  input  1  downstream accepts the parity word.
- out_parity  output  LANE_W  column parity C[x].
- out_col  output  3  column index x of out_parity, range 0..4.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse after column 4 parity is accepted.

Behaviour:
- Reset (reset==0, asynchronous):
  - state = IDLE; row = 0; col = 0; acc = 0.
  - out_parity = 0, out_col = 0.
  - in_ready, out_valid, busy, done all 0.
- Lane transfer: in_valid & in_ready on a rising edge. Output transfer: out_valid & out_ready on a rising edge.
- States: IDLE, ACCUM, EMIT, DONE.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - start=1 -> ACCUM; row = 0, col = 0, acc = 0.
  - in_valid is ignored.
- ACCUM:
  - in_ready = 1.
  - Lane transfer with row 0..3: acc <= (row==0 ? in_lane : acc ^ in_lane); row <= row+1.
  - Lane transfer with row==4: out_parity <= acc ^ in_lane; out_col <= col; row <= 0; -> EMIT.
  - No transfer: all state holds; in_valid gaps of any length are tolerated.
- EMIT:
  - in_ready = 0; out_valid = 1.
  - out_parity and out_col are held stable until the output transfer.
  - Output transfer with col < 4: col <= col+1; -> ACCUM.
  - Output transfer with col == 4: col <= 0; -> DONE.
- DONE: done = 1 for exactly one cycle, then -> IDLE unconditionally.
- Latency:
  - out_valid rises the cycle after the 5th lane of a column is accepted.
  - With no stalls a frame takes 25 lane cycles + 5 emit cycles + 1 done cycle = 31 cycles after start.
- Arithmetic: pure bitwise XOR over LANE_W; no carries.
- Row and col wrap 4 -> 0; values 5..7 are never reachable.
- start while busy is ignored: no restart, no state change.
- start in the same cycle as DONE is ignored; the block is in IDLE the following cycle.
- Reset mid-frame aborts immediately: the partial accumulation is discarded and no out_valid or done is produced.
- out_valid never drops without an output transfer, except on reset.
- in_ready is never high while out_valid is high; there is no input/output overlap.

Test Plan:
- Basic frame: start, then lanes A[x,y] = {x,y} replicated, no stalls -> C[x] = XOR of the 5 lanes for each x; out_col steps 0..4; done pulses at cycle 31.
- Constant lanes: all lanes = 0xFFFF_FFFF_FFFF_FFFF -> every C[x] = all ones (odd count). Then A[x,0] = A[x,1] = 0x1, others 0 -> C[x] = 0.
- Input gaps: in_valid toggles 1,0,0,1 randomly -> same parities as the stall-free run; row advances only on transfers.
- Output backpressure: out_ready held 0 for 7 cycles during col 2 -> out_valid stays 1, out_parity/out_col stable, in_ready = 0 throughout; resumes on out_ready=1.
- start while busy: pulse start at lane 12 -> ignored; frame completes normally with done once.
- Reset mid-frame: assert reset=0 after lane 8 -> outputs zero immediately. A new start plus a full frame then gives the correct C[0..4] with no leftover acc.
